shared_buff_pop_sched: RTL

Pop-side scheduler for the multi-queue shared buffer. It watches the buffer's per-queue valid flags and issues one-hot pop/pop_sel using weighted round-robin arbitration. It captures the buffer's combinational data_out into a 2-entry output FIFO and presents words to a downstream valid/ready consumer, tagged with their queue index. It is the consumer end of the buffer's pop interface and never violates the buffer's pop rules.

---
 rtl/shared_buff_pop_sched.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/shared_buff_pop_sched.sv
// Pop-side scheduler for the multi-queue shared buffer: weighted round-robin
// pop arbitration feeding a 2-entry output FIFO tagged with the queue index.
module shared_buff_pop_sched #(
  parameter int DW    = 16,
  parameter int Q     = 4,
  parameter int BURST = 1,
  localparam int QW   = $clog2(Q)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic [Q-1:0]  valid,
  input  logic [DW-1:0] data_in,
  output logic          pop,
  output logic [Q-1:0]  pop_sel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [QW-1:0] out_qid
);

  localparam int BCW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [Q-1:0] ONE_HOT0 = {{(Q-1){1'b0}}, 1'b1};

  logic [QW-1:0]  last_q, last_d;
  logic [BCW-1:0] burst_q, burst_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           out_valid_q, out_valid_d;
  logic [DW-1:0]  dat0_q, dat0_d, dat1_q, dat1_d;
  logic [QW-1:0]  qid0_q, qid0_d, qid1_q, qid1_d;

  logic [QW-1:0]  cand_s;
  logic [QW-1:0]  scan_s;
  logic [QW-1:0]  grant_s;
  logic           found_s;
  logic           cont_s;
  logic           pop_s;
  logic           rd_s;
  logic [Q-1:0]   sel_s;

  // base+step modulo Q; step never exceeds Q so one subtraction suffices
  function automatic logic [QW-1:0] wrap_idx(input logic [QW-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= Q) begin
      sum = sum - Q;
    end else begin
      sum = sum;
    end
    return QW'(sum);
  endfunction

  // Rotating scan for the first valid queue after last, plus burst continuation
  always_comb begin
    scan_s  = last_q;
    found_s = 1'b0;
    cand_s  = last_q;
    for (int k = 1; k <= Q; k++) begin
      cand_s = wrap_idx(last_q, k);
      if (!found_s && valid[cand_s]) begin
        found_s = 1'b1;
        scan_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    cont_s  = valid[last_q] && (int'(burst_q) < (BURST - 1));
    grant_s = cont_s ? last_q : scan_s;
  end

  // Pop strobe and select; pop is held off in reset and when both slots are full
  always_comb begin
    pop_s = arst_n && (|valid) && (cnt_q < 2'd2);
    if (pop_s) begin
      sel_s = ONE_HOT0 << grant_s;
    end else begin
      sel_s = {Q{1'b0}};
    end
  end

  // Arbitration state advances only on cycles that actually pop
  always_comb begin
    last_d  = last_q;
    burst_d = burst_q;
    if (pop_s) begin
      if (cont_s) begin
        burst_d = burst_q + BCW'(1);
      end else begin
        last_d  = scan_s;
        burst_d = {BCW{1'b0}};
      end
    end else begin
      last_d  = last_q;
      burst_d = burst_q;
    end
  end

  // Output FIFO: entry 0 is always the head so outputs come straight from flops
  always_comb begin
    rd_s   = out_valid_q && out_ready;
    cnt_d  = cnt_q;
    dat0_d = dat0_q;
    qid0_d = qid0_q;
    dat1_d = dat1_q;
    qid1_d = qid1_q;
    case (cnt_q)
      2'd0: begin
        if (pop_s) begin
          dat0_d = data_in;
          qid0_d = grant_s;
          cnt_d  = 2'd1;
        end else begin
          cnt_d  = 2'd0;
        end
      end
      2'd1: begin
        if (pop_s && rd_s) begin
          dat0_d = data_in;
          qid0_d = grant_s;
        end else if (pop_s) begin
          dat1_d = data_in;
          qid1_d = grant_s;
          cnt_d  = 2'd2;
        end else if (rd_s) begin
          cnt_d  = 2'd0;
        end else begin
          cnt_d  = 2'd1;
        end
      end
      2'd2: begin
        if (rd_s) begin
          dat0_d = dat1_q;
          qid0_d = qid1_q;
          cnt_d  = 2'd1;
        end else begin
          cnt_d  = 2'd2;
        end
      end
      default: begin
        cnt_d = 2'd0;
      end
    endcase
    out_valid_d = (cnt_d != 2'd0);
  end

  // State registers; reset gives queue 0 first priority via last = Q-1
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      last_q      <= QW'(Q - 1);
      burst_q     <= {BCW{1'b0}};
      cnt_q       <= 2'd0;
      out_valid_q <= 1'b0;
      dat0_q      <= {DW{1'b0}};
      qid0_q      <= {QW{1'b0}};
      dat1_q      <= {DW{1'b0}};
      qid1_q      <= {QW{1'b0}};
    end else begin
      last_q      <= last_d;
      burst_q     <= burst_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      dat0_q      <= dat0_d;
      qid0_q      <= qid0_d;
      dat1_q      <= dat1_d;
      qid1_q      <= qid1_d;
    end
  end

  assign pop       = pop_s;
  assign pop_sel   = sel_s;
  assign out_valid = out_valid_q;
  assign out_data  = dat0_q;
  assign out_qid   = qid0_q;

endmodule
